// File: rtl/mram_pkg.sv
// mram_pkg: constants, FSM state encoding and request struct shared by the
// MRAM access arbiter and its round-robin grant sub-module.
package mram_pkg;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 16;
  localparam int CNT_W       = 4;   // wait counter width, covers 1..15 cycles
  localparam int RD_WAIT_DEF = 4;
  localparam int WR_WAIT_DEF = 4;
  localparam int TURN_DEF    = 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SETUP      = 2'd1,
    STROBE     = 2'd2,
    TURNAROUND = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;     // {ub, lb}
  } mem_req_t;

  // Counter load value for a phase of w cycles (counts w-1 down to 0).
  function automatic logic [CNT_W-1:0] wait_ld(input int w);
    return (w <= 0) ? '0 : CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant.
//   valid[1:0]  - requesting ports
//   last_grant  - index of the port granted most recently
//   grant[1:0]  - one-hot grant, zero when nobody requests
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // contention: favour the port that did not win last time
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mram_access_arbiter.sv
// mram_access_arbiter: serialises two requesters (port 0 = I2C bridge,
// port 1 = auxiliary) onto one asynchronous MRAM.
//   FPGA_clk / FPGA_rst        - clock, synchronous active-high reset
//   reqN_valid/ready/we/addr/wdata/be - request handshake and fields
//   rsp_valid/rsp_id/rsp_rdata - one-cycle read response pulse
//   mem_addr/mem_wdata/mem_oe/mem_rdata - MRAM address, data, bus drive
//   chip_en/read_en/write_en/lb_en/ub_en - active-low MRAM strobes
// Each access runs SETUP (1 cycle) -> STROBE (RD_WAIT/WR_WAIT cycles) ->
// TURNAROUND (TURN cycles, skipped when 0) -> IDLE.
module mram_access_arbiter
  import mram_pkg::*;
#(
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF,
  parameter int TURN    = TURN_DEF
) (
  input  logic              FPGA_clk,
  input  logic              FPGA_rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [1:0]        req0_be,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [1:0]        req1_be,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              chip_en,
  output logic              read_en,
  output logic              write_en,
  output logic              lb_en,
  output logic              ub_en
);

  localparam logic [CNT_W-1:0] RD_LD   = wait_ld(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_LD   = wait_ld(WR_WAIT);
  localparam logic [CNT_W-1:0] TURN_LD = wait_ld(TURN);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_grant;
  logic             r_we, r_id;
  logic [1:0]       r_be;
  logic [1:0]       vld, gnt, rdy;
  logic             accept, sel_id, rsp_now, strb, mem_oe_nxt;
  mem_req_t         req [2];
  mem_req_t         sel;

  assign req[0] = {req0_we, req0_addr, req0_wdata, req0_be};
  assign req[1] = {req1_we, req1_addr, req1_wdata, req1_be};
  assign vld    = {req1_valid, req0_valid};

  rr_arbiter2 u_rr (
    .valid      (vld),
    .last_grant (last_grant),
    .grant      (gnt)
  );

  // Grant already implies valid, so ready is only raised for a live request.
  assign rdy        = (state == IDLE && !FPGA_rst) ? gnt : 2'b00;
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign accept     = |rdy;
  assign sel_id     = gnt[1];
  assign sel        = gnt[1] ? req[1] : req[0];

  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rsp_now   = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = SETUP;
      SETUP: begin
        // a write with no byte lanes enabled touches nothing
        if (r_we && r_be == 2'b00) begin
          state_nxt = (TURN == 0) ? IDLE : TURNAROUND;
          cnt_nxt   = TURN_LD;
        end else begin
          state_nxt = STROBE;
          cnt_nxt   = r_we ? WR_LD : RD_LD;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          rsp_now   = !r_we;
          state_nxt = (TURN == 0) ? IDLE : TURNAROUND;
          cnt_nxt   = TURN_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      TURNAROUND: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Bus drive is released one cycle after the write strobe rises: it is
    // held through the final TURNAROUND cycle (or the first IDLE cycle when
    // TURN=0) and cleared from there unless a new access is accepted.
    mem_oe_nxt = mem_oe;
    if (accept)
      mem_oe_nxt = sel.we;
    else if (state == IDLE || (state == TURNAROUND && state_nxt == IDLE))
      mem_oe_nxt = 1'b0;

    strb = (state_nxt == STROBE);
  end

  // Strobes are registered from the next state so the MRAM pins never glitch.
  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      cnt        <= '0;
      last_grant <= 1'b1;
      r_we       <= 1'b0;
      r_be       <= 2'b00;
      r_id       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_oe     <= 1'b0;
      chip_en    <= 1'b1;
      read_en    <= 1'b1;
      write_en   <= 1'b1;
      lb_en      <= 1'b1;
      ub_en      <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      cnt       <= cnt_nxt;
      mem_oe    <= mem_oe_nxt;
      chip_en   <= !strb;
      read_en   <= !(strb && !r_we);
      write_en  <= !(strb && r_we);
      lb_en     <= !(strb && (!r_we || r_be[0]));
      ub_en     <= !(strb && (!r_we || r_be[1]));
      rsp_valid <= rsp_now;
      if (rsp_now) begin
        rsp_id    <= r_id;
        rsp_rdata <= mem_rdata;
      end
      if (accept) begin
        last_grant <= sel_id;
        r_id       <= sel_id;
        r_we       <= sel.we;
        r_be       <= sel.be;
        mem_addr   <= sel.addr;
        mem_wdata  <= sel.wdata;
      end
    end
  end

endmodule

// File: tb/tb_mram_access_arbiter.sv
module tb_mram_access_arbiter;

  localparam int RDW = 4;
  localparam int TRN = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  v, we;
  logic [19:0] addr [2];
  logic [15:0] wd   [2];
  logic [1:0]  be   [2];
  logic        r0, r1, rsp_valid, rsp_id, mem_oe;
  logic [15:0] rsp_rdata, mem_wdata, mrd;
  logic [19:0] mem_addr;
  logic        chip_en, read_en, write_en, lb_en, ub_en;
  logic [1:0]  rdy;

  // second instance with TURN=0
  logic        z_v0, z_r0, z_r1, z_rsp_valid, z_rsp_id, z_oe;
  logic [15:0] z_rdata, z_wdata;
  logic [19:0] z_addr;
  logic        z_ce, z_re, z_we_n, z_lb, z_ub;

  int checks = 0, fails = 0, cyc = 0;
  logic [16:0] exp_q [$];
  int          grant_log [$];
  logic [15:0] ref_mem [int];
  logic [15:0] bus_mem [int];
  int ce_low, rd_low, wr_low, lb_low, ub_low, oe_falls, rsp_cnt, rsp_cyc;
  logic [15:0] last_rsp;
  logic [19:0] strobe_addr;

  assign rdy = {r1, r0};

  always #5 clk = ~clk;

  mram_access_arbiter dut (
    .FPGA_clk(clk), .FPGA_rst(rst),
    .req0_valid(v[0]), .req0_ready(r0), .req0_we(we[0]), .req0_addr(addr[0]),
    .req0_wdata(wd[0]), .req0_be(be[0]),
    .req1_valid(v[1]), .req1_ready(r1), .req1_we(we[1]), .req1_addr(addr[1]),
    .req1_wdata(wd[1]), .req1_be(be[1]),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_rdata(mrd),
    .chip_en(chip_en), .read_en(read_en), .write_en(write_en), .lb_en(lb_en), .ub_en(ub_en)
  );

  mram_access_arbiter #(.TURN(0)) dut0 (
    .FPGA_clk(clk), .FPGA_rst(rst),
    .req0_valid(z_v0), .req0_ready(z_r0), .req0_we(1'b0), .req0_addr(20'h00010),
    .req0_wdata(16'h0000), .req0_be(2'b11),
    .req1_valid(1'b0), .req1_ready(z_r1), .req1_we(1'b0), .req1_addr(20'h0),
    .req1_wdata(16'h0000), .req1_be(2'b00),
    .rsp_valid(z_rsp_valid), .rsp_id(z_rsp_id), .rsp_rdata(z_rdata),
    .mem_addr(z_addr), .mem_wdata(z_wdata), .mem_oe(z_oe), .mem_rdata(16'h1234),
    .chip_en(z_ce), .read_en(z_re), .write_en(z_we_n), .lb_en(z_lb), .ub_en(z_ub)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [15:0] bus_rd(input logic [19:0] a);
    return bus_mem.exists(int'(a)) ? bus_mem[int'(a)] : init_val(a);
  endfunction

  task automatic clear_cnt();
    ce_low = 0; rd_low = 0; wr_low = 0; lb_low = 0; ub_low = 0; oe_falls = 0;
  endtask

  // Present a request on port p (called at posedge+#1); returns the
  // acceptance cycle and records the expected outcome in the model.
  task automatic issue(input int p, input bit w, input logic [19:0] a,
                       input logic [15:0] d, input logic [1:0] b,
                       input bit expect_rsp, input bit keep, output int acc);
    logic [15:0] cur;
    v[p] = 1'b1; we[p] = w; addr[p] = a; wd[p] = d; be[p] = b;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rdy[p]) begin acc = cyc; break; end
    end
    chk($sformatf("accept_p%0d", p), (acc >= 0) ? 64'd1 : 64'd0, 64'd1);
    if (acc >= 0) begin
      grant_log.push_back(p);
      if (w) begin
        cur = ref_rd(a);
        if (b[0]) cur[7:0]  = d[7:0];
        if (b[1]) cur[15:8] = d[15:8];
        ref_mem[int'(a)] = cur;
      end else if (expect_rsp) begin
        exp_q.push_back({p[0], ref_rd(a)});
      end
    end
    @(posedge clk); #1;
    if (!keep) v[p] = 1'b0;
  endtask

  task automatic port_rand(input int p, input int n, input bit cont);
    int acc;
    bit w;
    for (int k = 0; k < n; k++) begin
      w = cont ? 1'b0 : 1'($urandom_range(0, 1));
      issue(p, w, 20'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)),
            1'b1, cont, acc);
      if (!cont) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    v[p] = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pops, strobe statistics and the MRAM bus model.
  initial begin
    logic [16:0] e;
    logic        prev_oe = 1'b0, prev_wen = 1'b1;
    logic [15:0] cur;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_cnt++; rsp_cyc = cyc; last_rsp = rsp_rdata;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {rsp_id, rsp_rdata}, 17'h0);
          checks++; fails++;
          $display("FAIL rsp_unexpected actual=%0h expected=none", {rsp_id, rsp_rdata});
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id_data", {rsp_id, rsp_rdata}, e);
        end
      end
      if (!chip_en) begin ce_low++; strobe_addr = mem_addr; end
      if (!read_en) rd_low++;
      if (!write_en) wr_low++;
      if (!write_en && !lb_en) lb_low++;
      if (!write_en && !ub_en) ub_low++;
      if (prev_oe && !mem_oe) begin
        oe_falls++;
        chk("oe_after_write_en_high", prev_wen, 1'b1);
      end
      prev_oe = mem_oe; prev_wen = write_en;
      if (!chip_en && !write_en) begin
        cur = bus_rd(mem_addr);
        if (!lb_en) cur[7:0]  = mem_wdata[7:0];
        if (!ub_en) cur[15:8] = mem_wdata[15:8];
        bus_mem[int'(mem_addr)] = cur;
      end
      mrd = (!chip_en && !read_en) ? bus_rd(mem_addr) : 16'hDEAD;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, rc, zr_cyc;
    int zacc [$];
    logic [15:0] zr_data, word;
    rst = 1'b1; v = 2'b00; we = 2'b00; z_v0 = 1'b0; mrd = 16'hDEAD;
    rsp_cnt = 0; rsp_cyc = -1; zr_cyc = -1; zr_data = '0;
    for (int p = 0; p < 2; p++) begin addr[p] = '0; wd[p] = '0; be[p] = '0; end
    clear_cnt();
    ref_mem[0] = 16'h5555; bus_mem[0] = 16'h5555;

    // reset state, with both requests pending
    repeat (2) @(posedge clk); #1 v = 2'b11;
    @(negedge clk);
    chk("rst_ready", rdy, 2'b00);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_rdata}, 18'h0);
    chk("rst_mem", {mem_addr, mem_wdata, mem_oe}, 37'h0);
    chk("rst_strobes", {chip_en, read_en, write_en, lb_en, ub_en}, 5'b11111);
    @(posedge clk); #1 v = 2'b00; rst = 1'b0;
    @(posedge clk); #1;

    // single read, port 0, address 0
    clear_cnt();
    issue(0, 1'b0, 20'h00000, 16'h0, 2'b11, 1'b1, 1'b0, a1);
    repeat (12) @(posedge clk); #1;
    chk("rd_rsp_cycle", rsp_cyc, a1 + 2 + RDW);
    chk("rd_rsp_data", last_rsp, 16'h5555);
    chk("rd_ce_low", ce_low, RDW);
    chk("rd_re_low", rd_low, RDW);
    chk("rd_we_low", wr_low, 0);

    // write, port 1, low byte only
    clear_cnt(); rc = rsp_cnt;
    issue(1, 1'b1, 20'hABCDE, 16'hA5A5, 2'b01, 1'b0, 1'b0, a1);
    repeat (12) @(posedge clk); #1;
    chk("wr_addr", strobe_addr, 20'hABCDE);
    chk("wr_we_low", wr_low, 4);
    chk("wr_lb_low", lb_low, 4);
    chk("wr_ub_low", ub_low, 0);
    chk("wr_re_low", rd_low, 0);
    chk("wr_oe_fell", (oe_falls > 0) ? 1 : 0, 1);
    chk("wr_no_rsp", rsp_cnt, rc);
    word = bus_rd(20'hABCDE);
    chk("wr_mem_word", word, ref_rd(20'hABCDE));

    // be=00 write is a no-op; next request follows quickly
    clear_cnt();
    issue(0, 1'b1, 20'h00005, 16'hFFFF, 2'b00, 1'b0, 1'b0, a1);
    issue(1, 1'b0, 20'h00005, 16'h0, 2'b11, 1'b1, 1'b0, a2);
    repeat (12) @(posedge clk); #1;
    chk("be0_no_write_strobe", wr_low, 0);
    chk("be0_ready_gap", (a2 - a1 >= 2 && a2 - a1 <= 2 + TRN) ? 1 : 0, 1);

    // continuous contention: 3 reads each, grants must alternate
    grant_log.delete();
    fork
      port_rand(0, 3, 1'b1);
      port_rand(1, 3, 1'b1);
    join
    repeat (12) @(posedge clk); #1;
    chk("rr_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("rr_grant%0d", i), grant_log[i], i % 2);

    // reset during the 2nd strobe cycle of a read
    clear_cnt(); rc = rsp_cnt;
    issue(0, 1'b0, 20'h00002, 16'h0, 2'b11, 1'b0, 1'b0, a1);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_mid_strobe", {chip_en, read_en}, 2'b00);
    @(negedge clk);
    chk("abort_strobes_high", {chip_en, read_en, write_en, lb_en, ub_en}, 5'b11111);
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("abort_no_rsp", rsp_cnt, rc);
    issue(0, 1'b0, 20'h00002, 16'h0, 2'b11, 1'b1, 1'b0, a1);
    repeat (12) @(posedge clk); #1;

    // randomised mixed traffic
    fork
      port_rand(0, 15, 1'b0);
      port_rand(1, 15, 1'b0);
    join
    repeat (20) @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    // TURN=0: back-to-back reads on port 0
    z_v0 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (z_rsp_valid && zr_cyc < 0) begin zr_cyc = cyc; zr_data = z_rdata; end
      if (z_r0) zacc.push_back(cyc);
      if (zacc.size() == 2) break;
    end
    @(posedge clk); #1 z_v0 = 1'b0;
    chk("t0_accepts", zacc.size(), 2);
    if (zacc.size() == 2) begin
      chk("t0_gap", zacc[1] - zacc[0], 2 + RDW);
      chk("t0_rsp_cycle", zr_cyc, zacc[0] + 2 + RDW);
    end
    chk("t0_rsp_data", zr_data, 16'h1234);
    repeat (10) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
